// File: rtl/bram_dump_reader.sv
// Streams a block of words out of the shared imem/dmem BRAM port onto a valid/ready interface.
// Optional macro DUMP_ADDR_TAG_EN adds m_addr, the byte address carried alongside each word.
module bram_dump_reader #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 128,
    parameter int NUM_COL = 4,
    localparam int LOGSIZE = $clog2(SIZE),
    localparam int AW      = LOGSIZE + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AW-1:0]      start_addr,
    input  logic [LOGSIZE+1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      shared_bram_addr,
    output logic [NUM_COL-1:0] bram_wr_en,
    output logic [WIDTH-1:0]   bram_din,
    input  logic [WIDTH-1:0]   bram_dout,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
`ifdef DUMP_ADDR_TAG_EN
    ,
    output logic [AW-1:0]      m_addr
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [AW-1:0]           rd_addr;
    logic [AW-1:0]           addr_q;
    logic [LOGSIZE+1:0]      reads_left;
    logic                    pipe_vld;
    logic                    pipe_last;
    logic [1:0][WIDTH-1:0]   fifo_data;
    logic [1:0]              fifo_last;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              occ;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    last_issue;

    assign bram_wr_en = '0;
    assign bram_din   = '0;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign m_valid = (occ != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid & fifo_last[rd_ptr];

    assign pop  = m_valid & m_ready;
    assign push = pipe_vld;

    // Never let queued plus in-flight words exceed the two FIFO slots.
    assign issue = (state == S_READ) && (reads_left != '0) &&
                   (({1'b0, occ} + {2'b0, pipe_vld} - {2'b0, pop}) < 3'd2);
    assign last_issue = issue && (reads_left == (LOGSIZE+2)'(1));

    // The address is presented combinationally in the issuing cycle so data returns one cycle later.
    assign shared_bram_addr = issue ? rd_addr : addr_q;

`ifdef DUMP_ADDR_TAG_EN
    logic [AW-1:0]        pipe_addr;
    logic [1:0][AW-1:0]   fifo_addr;

    assign m_addr = fifo_addr[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_addr <= '0;
            fifo_addr <= '0;
        end else begin
            if (issue) pipe_addr <= rd_addr;
            if (push)  fifo_addr[wr_ptr] <= pipe_addr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            addr_q     <= '0;
            reads_left <= '0;
            pipe_vld   <= 1'b0;
            pipe_last  <= 1'b0;
            fifo_data  <= '0;
            fifo_last  <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            pipe_vld  <= issue;
            pipe_last <= last_issue;

            if (issue) begin
                addr_q     <= rd_addr;
                rd_addr    <= rd_addr + AW'(4);
                reads_left <= reads_left - (LOGSIZE+2)'(1);
            end

            if (push) begin
                fifo_data[wr_ptr] <= bram_dout;
                fifo_last[wr_ptr] <= pipe_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr    <= start_addr & ~AW'(3);
                        reads_left <= word_count;
                        state      <= (word_count == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ:  if (last_issue) state <= S_DRAIN;
                S_DRAIN: if (pop && m_last) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dump_reader.sv
// Directed bench for bram_dump_reader; the BRAM model returns each word's own byte address.
module tb_bram_dump_reader;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 128;
    localparam int NUM_COL = 4;
    localparam int AW      = 10;
    localparam int CW      = 9;

    logic               clk;
    logic               reset;
    logic               start;
    logic [AW-1:0]      start_addr;
    logic [CW-1:0]      word_count;
    logic               busy;
    logic               done;
    logic [AW-1:0]      shared_bram_addr;
    logic [NUM_COL-1:0] bram_wr_en;
    logic [WIDTH-1:0]   bram_din;
    logic [WIDTH-1:0]   bram_dout;
    logic [WIDTH-1:0]   m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;

    bram_dump_reader #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .word_count       (word_count),
        .busy             (busy),
        .done             (done),
        .shared_bram_addr (shared_bram_addr),
        .bram_wr_en       (bram_wr_en),
        .bram_din         (bram_din),
        .bram_dout        (bram_dout),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bram_dout <= WIDTH'(shared_bram_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] got_d[$];
    bit               got_l[$];
    int               got_c[$];
    int               done_c[$];

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_c.push_back(cyc);
        end
        if (done) done_c.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        done_c.delete();
    endtask

    task automatic kick(input logic [AW-1:0] a, input logic [CW-1:0] n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_count = n;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (done_c.size() == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done_seen"}, (done_c.size() > 0) ? 1 : 0, 1);
    endtask

    task automatic wait_words(input string tag, input int n, input int bound);
        int k = 0;
        while (got_d.size() < n && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, " words_seen"}, (got_d.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic chk_stream(input string tag, input logic [AW-1:0] a, input int n);
        logic [AW-1:0] e;
        chk({tag, " count"}, got_d.size(), n);
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            e = a + AW'(4 * i);
            chk($sformatf("%s data[%0d]", tag, i), got_d[i], WIDTH'(e));
            chk($sformatf("%s last[%0d]", tag, i), got_l[i], (i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        logic [AW-1:0] a0;
        reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_last", m_last, 0);
        chk("rst m_data", m_data, 0);
        chk("rst addr", shared_bram_addr, 0);
        chk("rst wr_en", bram_wr_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic 4-word dump at full rate
        clear_q();
        kick(10'd0, 9'd4);
        wait_done("t1", 40);
        chk_stream("t1", 10'd0, 4);
        if (got_c.size() == 4 && done_c.size() > 0) begin
            chk("t1 first_latency", got_c[0] - s, 3);
            chk("t1 back_to_back", got_c[3] - got_c[0], 3);
            chk("t1 done_after_last", done_c[0] - got_c[3], 1);
        end
        @(negedge clk);
        chk("t1 done_one_cycle", done, 0);
        chk("t1 idle_busy", busy, 0);

        // Stall while the second word is presented
        clear_q();
        kick(10'd0, 9'd4);
        wait_words("t2", 1, 20);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t2 stall_valid[%0d]", i), m_valid, 1);
            chk($sformatf("t2 stall_data[%0d]", i), m_data, 4);
            chk($sformatf("t2 stall_last[%0d]", i), m_last, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_done("t2", 40);
        chk_stream("t2", 10'd0, 4);

        // Address wrap at the top of the byte space
        clear_q();
        kick(10'd1020, 9'd3);
        wait_done("t3", 40);
        chk_stream("t3", 10'd1020, 3);

        // Zero-length dump
        @(negedge clk);
        a0 = shared_bram_addr;
        clear_q();
        kick(10'd100, 9'd0);
        wait_done("t4", 10);
        if (done_c.size() > 0) chk("t4 done_latency", done_c[0] - s, 1);
        repeat (3) @(negedge clk);
        chk("t4 no_words", got_d.size(), 0);
        chk("t4 addr_held", shared_bram_addr, a0);

        // Reset in the middle of a long dump, then a fresh dump
        clear_q();
        kick(10'd0, 9'd10);
        wait_words("t5", 2, 20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5 busy_after_rst", busy, 0);
        chk("t5 valid_after_rst", m_valid, 0);
        clear_q();
        kick(10'd8, 9'd2);
        wait_done("t5", 40);
        chk_stream("t5", 10'd8, 2);

        // Start while busy is ignored
        clear_q();
        kick(10'd0, 9'd4);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 10'd512; word_count = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6", 40);
        chk_stream("t6", 10'd0, 4);
        repeat (3) @(negedge clk);
        chk("t6 idle_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_dump_reader.md
BRAM_DUMP_READER -- requirements
Module: bram_dump_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter SIZE, default 128, words per memory (imem and dmem each).
REQ-003 SHALL have parameter NUM_COL, default 4, byte-write columns.
REQ-004 SHALL use localparam LOGSIZE = $clog2(SIZE), with address width AW = LOGSIZE+3 covering imem plus dmem byte space.
REQ-005 clk  in  1  single clock; every register updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request a dump; sampled only in IDLE.
REQ-008 start_addr  in  AW  starting byte address; bits [1:0] ignored.
REQ-009 word_count  in  LOGSIZE+2  number of words to read, range 0..2*SIZE.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 shared_bram_addr  out  AW  byte address to the shared BRAM port.
REQ-013 bram_wr_en  out  NUM_COL  tied to all-zero; the block never writes.
REQ-014 bram_din  out  WIDTH  tied to zero.
REQ-015 bram_dout  in  WIDTH  BRAM read data, valid one cycle after the address is presented.
REQ-016 m_data  out  WIDTH  output stream data.
REQ-017 m_valid  out  1  output stream valid.
REQ-018 m_ready  in  1  output stream ready.
REQ-019 m_last  out  1  high with the final word of a dump.

Function
REQ-020 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-021 SHALL move from IDLE to READ when start=1 and word_count!=0, latching the word-aligned start_addr and word_count.
REQ-022 SHALL move from IDLE to DONE when start=1 and word_count==0; no BRAM read is issued and m_valid is never asserted.
REQ-023 SHALL ignore start in every state except IDLE.
REQ-024 In READ, SHALL issue one read per cycle while reads remain and (FIFO occupancy + reads in flight - pop this cycle) < 2.
REQ-025 Each issued read SHALL drive shared_bram_addr with the current address, then advance the address by 4 modulo 2^AW (1020 wraps to 0 for SIZE=128).
REQ-026 SHALL capture bram_dout into a 2-entry FIFO at the end of the cycle after the read is issued.
REQ-027 SHALL move from READ to DRAIN in the cycle the last read issues.
REQ-028 SHALL move from DRAIN to DONE on the handshake (m_valid & m_ready) of the final word.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 m_valid SHALL equal FIFO non-empty, and m_data SHALL be the FIFO head.
REQ-031 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-032 A simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-033 With m_ready held at 1, SHALL sustain one word per cycle.
REQ-034 The first m_valid SHALL occur in the 3rd cycle after the edge that samples start.
REQ-035 Words SHALL be delivered in address order with no loss or duplication.
REQ-036 shared_bram_addr SHALL hold its last value when no read issues.

Reset
REQ-037 On reset, SHALL enter IDLE, empty the FIFO and discard in-flight reads; this applies mid-operation too.
REQ-038 On reset, SHALL clear busy, done, m_valid, m_last, m_data and shared_bram_addr to 0.
REQ-039 m_valid SHALL be 0 in the cycle after reset is sampled.

Configuration
REQ-040 With the macro DUMP_ADDR_TAG_EN defined, SHALL add output port m_addr (AW bits), carrying the byte address of each word and registered alongside m_data in the FIFO.
REQ-041 Without DUMP_ADDR_TAG_EN, the m_addr port and its FIFO storage SHALL be absent; all other behaviour is identical.

Verification
REQ-042 BRAM preloaded with word(addr)=addr; start_addr=0, word_count=4, m_ready=1 -> m_data 0,4,8,12 on consecutive cycles; m_last only with 12; done pulses 1 cycle after the last handshake.
REQ-043 Same dump with m_ready=0 for 5 cycles after the 2nd word -> m_data stays 4 during the stall, then 8,12 follow; no drops or repeats.
REQ-044 start_addr=1020, word_count=3 -> m_data 1020, 0, 4.
REQ-045 word_count=0 -> done=1 in the cycle after start; m_valid stays 0 and shared_bram_addr is unchanged.
REQ-046 reset asserted after the 2nd word of a 10-word dump -> next cycle busy=0 and m_valid=0; a following start_addr=8, word_count=2 -> m_data 8, 12.
REQ-047 start pulsed while busy with a different start_addr -> ignored; the original dump completes unchanged.
